// File: rtl/pool_relu_layer.sv
// ReLU + 2x2/stride-2 max/average pooling over CH parallel channels, raster order in and out.
// Latency 1 cycle from the (odd row, odd col) beat; no backpressure, in_valid may gap freely.
module pool_relu_layer #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic                                                pool_mode,
    input  logic                                                relu_en,
    input  logic                                                in_valid,
    input  logic [CH*DW-1:0]                                    d_in,
    output logic                                                out_valid,
    output logic [CH*DW-1:0]                                    d_out,
    output logic [((IMG_W/2 > 1) ? $clog2(IMG_W/2) : 1)-1:0]    out_col,
    output logic [((IMG_H/2 > 1) ? $clog2(IMG_H/2) : 1)-1:0]    out_row,
    output logic                                                busy,
    output logic                                                done
);

    localparam int HW  = IMG_W / 2;
    localparam int HH  = IMG_H / 2;
    localparam int CW  = (HW > 1) ? $clog2(HW) : 1;
    localparam int RW  = (HH > 1) ? $clog2(HH) : 1;
    localparam int CBW = $clog2(IMG_W);
    localparam int RBW = $clog2(IMG_H);
    localparam logic signed [DW+1:0] RND = 2;

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
        $error("pool_relu_layer: IMG_W and IMG_H must be even and at least 2");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CBW-1:0]      col_q, col_d;
    logic [RBW-1:0]      row_q, row_d;
    logic                mode_q, relu_q;
    logic signed [DW-1:0] hold_q [CH];
    logic signed [DW:0]  lbuf_q [HW][CH];

    logic                out_valid_q, done_q;
    logic [CH*DW-1:0]    d_out_q;
    logic [CW-1:0]       out_col_q;
    logic [RW-1:0]       out_row_q;

    logic                acc, col_odd, row_odd, last_col, last_row;
    logic [CW-1:0]       lidx;
    logic [RW-1:0]       ridx;

    logic signed [DW-1:0] d_c  [CH];
    logic signed [DW-1:0] x_c  [CH];
    logic signed [DW:0]   hw_c [CH];
    logic signed [DW:0]   xw_c [CH];
    logic signed [DW:0]   p_c  [CH];
    logic signed [DW+1:0] bw_c [CH];
    logic signed [DW+1:0] pw_c [CH];
    logic signed [DW+1:0] r_c  [CH];
    logic signed [DW+1:0] a_c  [CH];
    logic [CH*DW-1:0]     res_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start in RUN restarts the frame; done_q marks the final output cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (!start && done_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
    end

    always_comb begin
        acc      = (state_q == ST_RUN) && !start && in_valid && !done_q;
        col_odd  = col_q[0];
        row_odd  = row_q[0];
        last_col = (col_q == CBW'(IMG_W - 1));
        last_row = (row_q == RBW'(IMG_H - 1));
        lidx     = CW'(col_q >> 1);
        ridx     = RW'(row_q >> 1);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start) begin
            col_d = '0;
            row_d = '0;
        end else if (acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Horizontal pair pooled at DW+1 bits, vertical pair at DW+2 so average sums never wrap.
    always_comb begin
        res_d = '0;
        for (int c = 0; c < CH; c++) begin
            d_c[c]  = $signed(d_in[c*DW +: DW]);
            x_c[c]  = (relu_q && d_c[c][DW-1]) ? '0 : d_c[c];
            hw_c[c] = hold_q[c];
            xw_c[c] = x_c[c];
            p_c[c]  = mode_q ? (hw_c[c] + xw_c[c])
                             : ((hw_c[c] > xw_c[c]) ? hw_c[c] : xw_c[c]);
            bw_c[c] = lbuf_q[lidx][c];
            pw_c[c] = p_c[c];
            r_c[c]  = mode_q ? (bw_c[c] + pw_c[c])
                             : ((bw_c[c] > pw_c[c]) ? bw_c[c] : pw_c[c]);
            a_c[c]  = (r_c[c] + RND) >>> 2;
            res_d[c*DW +: DW] = mode_q ? DW'(a_c[c]) : DW'(r_c[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            d_out_q     <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= acc && col_odd && row_odd;
            done_q      <= acc && last_col && last_row;
            if (start) begin
                mode_q <= pool_mode;
                relu_q <= relu_en;
            end
            if (acc && col_odd && row_odd) begin
                d_out_q   <= res_d;
                out_col_q <= lidx;
                out_row_q <= ridx;
            end
            for (int c = 0; c < CH; c++) begin
                if (acc && !col_odd) hold_q[c] <= x_c[c];
            end
        end
    end

    // Line buffer holds even-row pairs; every entry is rewritten before the odd row reads it.
    always_ff @(posedge clk) begin
        if (acc && col_odd && !row_odd) begin
            for (int c = 0; c < CH; c++) begin
                lbuf_q[lidx][c] <= p_c[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign d_out     = d_out_q;
    assign out_col   = out_col_q;
    assign out_row   = out_row_q;
    assign done      = done_q;

endmodule
